// File: rtl/mc_mips_core.sv
// mc_mips_core: multi-cycle MIPS-subset core sharing one valid/ack port for fetch and data.
// Define MC_PORT_IO_EN to map PortIn/PortOut at PORT_ADDR.
module mc_mips_core #(
  parameter logic [31:0] RESET_PC      = 32'h0040_0000,
  parameter int          PORT_IN_WIDTH = 8,
  parameter logic [31:0] PORT_ADDR     = 32'h1001_0024
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_ack,
  input  logic [PORT_IN_WIDTH-1:0] PortIn,
  output logic [31:0]              PortOut,
  output logic [31:0]              ALUResultOut,
  output logic                     instr_retired,
  output logic                     illegal_op
);

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_NOR = 6'h27;

  function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [4:0] sh, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] imm_s,
                                        input logic [15:0] imm);
    logic [31:0] r;
    r = a + imm_s;
    case (op)
      OP_R: begin
        case (fn)
          F_ADD:   r = a + b;
          F_SUB:   r = a - b;
          F_AND:   r = a & b;
          F_OR:    r = a | b;
          F_NOR:   r = ~(a | b);
          F_SLL:   r = b << sh;
          F_SRL:   r = b >> sh;
          default: r = a;
        endcase
      end
      OP_ORI:         r = a | {16'h0000, imm};
      OP_LUI:         r = {imm, 16'h0000};
      OP_BEQ, OP_BNE: r = a - b;
      default:        r = a + imm_s;
    endcase
    return r;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_q, alu_d, mdr_q, mdr_d, port_out_q, port_out_d;
  logic [31:0] rf_q [32];
  logic        rf_we, retire, legal;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]         opcode, funct;
  logic [4:0]         rs, rt, rd, shamt;
  logic [15:0]        imm16;
  logic signed [31:0] simm;
  logic               is_rtype, is_beq, is_bne, is_j, is_jal, is_jr, is_lw, is_sw;
  logic               port_lw, port_sw;
  logic [31:0]        port_in_ext;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm16    = ir_q[15:0];
  assign simm     = {{16{imm16[15]}}, imm16};
  assign is_rtype = (opcode == OP_R);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jr    = is_rtype && (funct == F_JR);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);

`ifdef MC_PORT_IO_EN
  logic port_hit;
  assign port_hit    = ({alu_q[31:2], 2'b00} == PORT_ADDR);
  assign port_lw     = is_lw && port_hit;
  assign port_sw     = is_sw && port_hit;
  assign port_in_ext = 32'(PortIn);
`else
  logic unused_port;
  assign unused_port = ^{PortIn, PORT_ADDR};
  assign port_lw     = 1'b0;
  assign port_sw     = 1'b0;
  assign port_in_ext = '0;
`endif

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R:    legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLL, F_SRL, F_JR};
      OP_ADDI, OP_ORI, OP_LUI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_J, OP_JAL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Reset forces the port idle combinationally so an aborted store never reaches memory.
  assign mem_req   = !reset && ((state_q == S_FETCH) || ((state_q == S_MEM) && !port_lw));
  assign mem_we    = !reset && (state_q == S_MEM) && is_sw;
  assign mem_addr  = (state_q == S_FETCH) ? pc_q : {alu_q[31:2], 2'b00};
  assign mem_wdata = b_q;

  assign instr_retired = retire && !reset;
  assign illegal_op    = !reset && (state_q == S_DECODE) && !legal;
  assign PortOut       = port_out_q;
  assign ALUResultOut  = alu_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_d      = alu_q;
    mdr_d      = mdr_q;
    port_out_d = port_out_q;
    rf_we      = 1'b0;
    rf_waddr   = 5'd0;
    rf_wdata   = 32'd0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_req && mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rf_q[rs];
        b_d = rf_q[rt];
        if (legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTE: begin
        alu_d   = alu_f(opcode, funct, shamt, a_q, b_q, $unsigned(simm), imm16);
        state_d = S_WB;
        // pc_q already holds PC+4 here, so branch targets and the link value build on it.
        if (is_beq || is_bne) begin
          state_d = S_FETCH;
          retire  = 1'b1;
          if ((a_q == b_q) == is_beq) pc_d = pc_q + $unsigned(simm <<< 2);
        end else if (is_j || is_jal) begin
          state_d = S_FETCH;
          retire  = 1'b1;
          pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
          if (is_jal) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_q;
          end
        end else if (is_jr) begin
          state_d = S_FETCH;
          retire  = 1'b1;
          pc_d    = a_q;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (port_lw) begin
          mdr_d   = port_in_ext;
          state_d = S_WB;
        end else if (mem_req && mem_ack) begin
          if (is_sw) begin
            state_d = S_FETCH;
            retire  = 1'b1;
            if (port_sw) port_out_d = b_q;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = is_rtype ? rd : rt;
        rf_wdata = is_lw ? mdr_q : alu_q;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      mdr_q      <= '0;
      port_out_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_q      <= alu_d;
      mdr_q      <= mdr_d;
      port_out_q <= port_out_d;
      if (rf_we && (rf_waddr != 5'd0)) rf_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mc_mips_core.sv
// Bench for mc_mips_core: wait-state memory model, per-instruction retire trace and table compare.
module tb_mc_mips_core;

  localparam logic [31:0] RPC   = 32'h0040_0000;
  localparam logic [31:0] DBASE = 32'h1001_0000;
  localparam logic [31:0] PADDR = 32'h1001_0024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  port_in = 8'hA5;
  logic [31:0] PortOut, ALUResultOut;
  logic        instr_retired, illegal_op;

  always #5 clk = ~clk;

  mc_mips_core dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .PortIn(port_in),
    .PortOut(PortOut), .ALUResultOut(ALUResultOut), .instr_retired(instr_retired),
    .illegal_op(illegal_op)
  );

  // Memory model: text at 0x0040_xxxx and data at 0x1001_xxxx kept apart by address bit 28.
  logic [31:0] mem [0:2047];
  int wait_cfg = 0;
  int wcnt = 0;
  int nwr = 0;

  function automatic int idx(input logic [31:0] a);
    return int'({a[28], a[11:2]});
  endfunction

  assign mem_rdata = mem[idx(mem_addr)];
  assign mem_ack   = mem_req && (wcnt == wait_cfg);

  always @(posedge clk) begin
    if (mem_req && mem_ack && mem_we) begin
      mem[idx(mem_addr)] = mem_wdata;
      nwr = nwr + 1;
    end
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Retire trace recorder
  int          cyc, n_ret, stab_bad, stab_cnt, port_rd;
  int          cyc_a [64];
  logic [31:0] fa_a [64];
  logic [31:0] alu_a [64];
  logic        ill_a [64];
  logic [31:0] cur_fa, p_addr, p_wdata;
  logic        p_we;
  bit          alu_pend, held;

  initial begin
    stab_bad = 0;
    stab_cnt = 0;
    port_rd  = 0;
  end

  always @(negedge clk) begin
    if (reset) begin
      cyc = 0; n_ret = 0; alu_pend = 0; held = 0;
    end else begin
      cyc++;
      if (alu_pend && n_ret > 0 && n_ret <= 64) alu_a[n_ret-1] = ALUResultOut;
      alu_pend = 0;
      if (cyc == 1) cur_fa = mem_addr;
      if (held) begin
        stab_cnt++;
        if (!mem_req || mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata) stab_bad++;
      end
      held    = mem_req && !mem_ack;
      p_addr  = mem_addr;
      p_we    = mem_we;
      p_wdata = mem_wdata;
      if (mem_req && !mem_we && mem_addr == PADDR) port_rd++;
      if (instr_retired) begin
        if (n_ret < 64) begin
          cyc_a[n_ret] = cyc;
          fa_a[n_ret]  = cur_fa;
          ill_a[n_ret] = illegal_op;
        end
        n_ret++;
        cyc = 0;
        alu_pend = 1;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] fa;
    int          cycles;
    logic [31:0] alu;
    bit          chk_alu;
    bit          ill;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [31:0] off, input int c, input logic [31:0] alu,
                     input bit ca, input bit ill);
    vec_t v;
    v.fa = RPC + off; v.cycles = c; v.alu = alu; v.chk_alu = ca; v.ill = ill;
    vq.push_back(v);
  endtask

  task automatic check_trace(input string tag);
    foreach (vq[i]) begin
      chk($sformatf("%s_fetch%0d", tag, i), fa_a[i], vq[i].fa);
      chk($sformatf("%s_cycles%0d", tag, i), 32'(cyc_a[i]), 32'(vq[i].cycles));
      chk($sformatf("%s_illegal%0d", tag, i), 32'(ill_a[i]), 32'(vq[i].ill));
      if (vq[i].chk_alu) chk($sformatf("%s_alu%0d", tag, i), alu_a[i], vq[i].alu);
    end
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] w);
    mem[idx(RPC + off)] = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget);
    int k;
    k = 0;
    while (n_ret < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("run_complete", (n_ret >= n) ? 32'd1 : 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr0;
    bit found;

    // ---------------- Phase 1: zero-wait ALU / branch / jump program
    clear_mem();
    wr(32'h00, 32'h20080005); wr(32'h04, 32'h01084820); wr(32'h08, 32'h3C0A1001);
    wr(32'h0C, 32'hAD490000); wr(32'h10, 32'h8D4B0000); wr(32'h14, 32'h01686022);
    wr(32'h18, 32'h340D8001); wr(32'h1C, 32'h200EFFFF); wr(32'h20, 32'h01CE7820);
    wr(32'h24, 32'h00088100); wr(32'h28, 32'h000E8F02); wr(32'h2C, 32'h01009027);
    wr(32'h30, 32'h01C89824); wr(32'h34, 32'h0110A025); wr(32'h38, 32'hFC000000);
    wr(32'h3C, 32'h15080005); wr(32'h40, 32'h10000001); wr(32'h44, 32'h20080063);
    wr(32'h48, 32'h0C100040); wr(32'h100, 32'hAD5F0004); wr(32'h104, 32'h03E00008);
    wr(32'h4C, 32'hAD4F0008); wr(32'h50, 32'hAD51000C); wr(32'h54, 32'hAD4D0010);
    wr(32'h58, 32'hAD540014); wr(32'h5C, 32'hAD480018); wr(32'h60, 32'h1000FFFF);

    vq.delete();
    add(32'h00, 4, 32'd5, 1, 0);          add(32'h04, 4, 32'd10, 1, 0);
    add(32'h08, 4, 32'h10010000, 1, 0);   add(32'h0C, 4, 32'h10010000, 1, 0);
    add(32'h10, 5, 32'h10010000, 1, 0);   add(32'h14, 4, 32'd5, 1, 0);
    add(32'h18, 4, 32'h00008001, 1, 0);   add(32'h1C, 4, 32'hFFFFFFFF, 1, 0);
    add(32'h20, 4, 32'hFFFFFFFE, 1, 0);   add(32'h24, 4, 32'h50, 1, 0);
    add(32'h28, 4, 32'hF, 1, 0);          add(32'h2C, 4, 32'hFFFFFFFA, 1, 0);
    add(32'h30, 4, 32'd5, 1, 0);          add(32'h34, 4, 32'h55, 1, 0);
    add(32'h38, 2, 32'h55, 1, 1);         add(32'h3C, 3, 32'd0, 0, 0);
    add(32'h40, 3, 32'd0, 0, 0);          add(32'h48, 3, 32'd0, 0, 0);
    add(32'h100, 4, 32'h10010004, 1, 0);  add(32'h104, 3, 32'd0, 0, 0);
    add(32'h4C, 4, 32'h10010008, 1, 0);   add(32'h50, 4, 32'h1001000C, 1, 0);
    add(32'h54, 4, 32'h10010010, 1, 0);   add(32'h58, 4, 32'h10010014, 1, 0);
    add(32'h5C, 4, 32'h10010018, 1, 0);   add(32'h60, 3, 32'd0, 0, 0);
    add(32'h60, 3, 32'd0, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_retired", 32'(instr_retired), 32'd0);
    release_reset();
    @(negedge clk);
    chk("rst_first_fetch", mem_addr, RPC);
    chk("rst_fetch_req", 32'(mem_req), 32'd1);
    chk("rst_alu_out", ALUResultOut, 32'd0);
    chk("rst_port_out", PortOut, 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    run_until(vq.size(), 600);
    check_trace("p1");
    chk("p1_sw_add", mem[idx(DBASE)], 32'd10);
    chk("p1_jal_link", mem[idx(DBASE + 32'h04)], 32'h0040004C);
    chk("p1_add_wrap", mem[idx(DBASE + 32'h08)], 32'hFFFFFFFE);
    chk("p1_srl", mem[idx(DBASE + 32'h0C)], 32'h0000000F);
    chk("p1_ori_zext", mem[idx(DBASE + 32'h10)], 32'h00008001);
    chk("p1_or", mem[idx(DBASE + 32'h14)], 32'h00000055);
    chk("p1_r8_kept", mem[idx(DBASE + 32'h18)], 32'd5);

    // ---------------- Phase 2: two wait cycles on every access
    reset = 1'b1;
    wait_cfg = 2;
    clear_mem();
    wr(32'h00, 32'h3C0A1001); wr(32'h04, 32'h2009000A); wr(32'h08, 32'hAD490000);
    wr(32'h0C, 32'h8D4B0000); wr(32'h10, 32'hAD4B0004); wr(32'h14, 32'h1000FFFF);
    vq.delete();
    add(32'h00, 6, 32'h10010000, 1, 0);  add(32'h04, 6, 32'd10, 1, 0);
    add(32'h08, 8, 32'h10010000, 1, 0);  add(32'h0C, 9, 32'h10010000, 1, 0);
    add(32'h10, 8, 32'h10010004, 1, 0);  add(32'h14, 5, 32'd0, 0, 0);
    add(32'h14, 5, 32'd0, 0, 0);
    repeat (2) @(negedge clk);
    release_reset();
    run_until(vq.size(), 400);
    check_trace("p2");
    chk("p2_sw_mem", mem[idx(DBASE)], 32'd10);
    chk("p2_lw_back", mem[idx(DBASE + 32'h04)], 32'd10);
    chk("p2_held_seen", (stab_cnt > 0) ? 32'd1 : 32'd0, 32'd1);
    chk("p2_stable", 32'(stab_bad), 32'd0);

    // ---------------- Phase 3: reset during the MEM state of a store
    reset = 1'b1;
    clear_mem();
    wr(32'h00, 32'h3C0A1001); wr(32'h04, 32'h2009000A); wr(32'h08, 32'hAD490000);
    repeat (2) @(negedge clk);
    release_reset();
    nwr0 = nwr;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (mem_req && mem_we) found = 1;
    end
    chk("p3_store_seen", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    chk("p3_rst_req", 32'(mem_req), 32'd0);
    chk("p3_rst_we", 32'(mem_we), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("p3_fetch_reset_pc", mem_addr, RPC);
    chk("p3_fetch_req", 32'(mem_req), 32'd1);
    chk("p3_no_write", 32'(nwr - nwr0), 32'd0);
    chk("p3_mem_clean", mem[idx(DBASE)], 32'd0);

    // ---------------- Phase 4: load/store at the I/O port address
    reset = 1'b1;
    wait_cfg = 0;
    clear_mem();
    mem[idx(PADDR)] = 32'hDEADBEEF;
    wr(32'h00, 32'h3C0A1001); wr(32'h04, 32'h8D4B0024); wr(32'h08, 32'h340C1234);
    wr(32'h0C, 32'hAD4C0024); wr(32'h10, 32'hAD4B0000); wr(32'h14, 32'h1000FFFF);
    vq.delete();
    add(32'h00, 4, 32'h10010000, 1, 0);  add(32'h04, 5, 32'h10010024, 1, 0);
    add(32'h08, 4, 32'h00001234, 1, 0);  add(32'h0C, 4, 32'h10010024, 1, 0);
    add(32'h10, 4, 32'h10010000, 1, 0);  add(32'h14, 3, 32'd0, 0, 0);
    repeat (2) @(negedge clk);
    release_reset();
    run_until(vq.size(), 300);
    check_trace("p4");
    chk("p4_mem_store", mem[idx(PADDR)], 32'h00001234);
`ifdef MC_PORT_IO_EN
    chk("p4_port_lw", mem[idx(DBASE)], 32'h000000A5);
    chk("p4_port_out", PortOut, 32'h00001234);
    chk("p4_no_port_read", 32'(port_rd), 32'd0);
`else
    chk("p4_plain_lw", mem[idx(DBASE)], 32'hDEADBEEF);
    chk("p4_port_out_tied", PortOut, 32'd0);
`endif
    chk("all_stable", 32'(stab_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
